multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle RV32I core. It decodes the latched instruction word and sequences fetch, decode, execute, memory and writeback stages. It drives the register-file and operand-select controls (RegWrite, MtoR, AluSrcA, AluSrcB, current_stage), plus ALU, memory, IR and PC controls. It sits between instruction/data memory handshakes and the datapath, and is the initiator for every register-file read and writeback.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- instr  in  32  instruction register contents (valid from DECODE onward)
- mem_ready  in  1  memory handshake; access completes in the cycle it is 1
- alu_cond  in  1  ALU branch-condition result for instr funct3 (valid in BR_CMP)
- current_stage  out  5  encoded FSM state
- RegWrite  out  1  register writeback enable
- MtoR  out  2  writeback source: 0 ALU out, 1 load data, 2 immediate
- AluSrcA  out  1  0 pc, 1 rs1
- AluSrcB  out  2  0 rs2, 1 constant 4, 2 immediate
- alu_op  out  2  0 ADD, 1 R-funct, 2 I-funct, 3 branch compare
- IRWrite  out  1  latch instruction from memory
- MemRead  out  1  memory read request (fetch or load)
- MemWrite  out  1  store request
- PCWrite  out  1  PC update enable
- PCSrc  out  2  0 pc+4 incrementer, 1 ALU result, 2 ALU result & ~1
- illegal_instr  out  1  sticky illegal-opcode flag

## Operation
- States and current_stage codes: FETCH 0, DECODE 1, EXEC 2, WB_ALU 3, MEM_ADDR 4, MEM_RD 5, WB_LD 6, MEM_WR 7, BR_CMP 8, BR_TGT 9, WB_LUI 10, AUIPC_EX 11, WB_AUIPC 12, JAL_LINK 13, WB_JAL 14, JALR_LINK 15, WB_JALR 16, HALT 31.
- FETCH: MemRead=1, AluSrcA=0, AluSrcB=1. IRWrite=mem_ready. On mem_ready go to DECODE, else stay.
- DECODE: RegWrite=0; the register file captures rs1/rs2. Dispatch on instr[6:0]:
  - 0110011 or 0010011: EXEC
  - 0000011 or 0100011: MEM_ADDR
  - 1100011: BR_CMP
  - 0110111: WB_LUI
  - 0010111: AUIPC_EX
  - 1101111: JAL_LINK
  - 1100111: JALR_LINK
  - 0001111 or 1110011: NOP (PCWrite=1, PCSrc=0, go to FETCH)
  - any other opcode: illegal (see Configuration)
- EXEC: AluSrcA=1. R-type: AluSrcB=0, alu_op=1. I-type: AluSrcB=2, alu_op=2. Then WB_ALU.
- WB_ALU, WB_AUIPC: RegWrite=1, MtoR=0, PCWrite=1, PCSrc=0. Then FETCH.
- MEM_ADDR: AluSrcA=1, AluSrcB=2, alu_op=0. Load goes to MEM_RD, store goes to MEM_WR.
- MEM_RD: MemRead=1. Hold until mem_ready, then WB_LD.
- WB_LD: RegWrite=1, MtoR=1, PCWrite=1, PCSrc=0. Then FETCH.
- MEM_WR: MemWrite=1. Hold until mem_ready. PCWrite=mem_ready, PCSrc=0. On ready go to FETCH.
- BR_CMP: AluSrcA=1, AluSrcB=0, alu_op=3. Register taken<=alu_cond. Then BR_TGT.
- BR_TGT: AluSrcA=0, AluSrcB=2, alu_op=0, PCWrite=1, PCSrc=taken?1:0. Then FETCH.
- WB_LUI: RegWrite=1, MtoR=2, PCWrite=1, PCSrc=0. Then FETCH.
- AUIPC_EX: AluSrcA=0, AluSrcB=2, alu_op=0. Then WB_AUIPC.
- JAL_LINK / JALR_LINK: AluSrcA=0, AluSrcB=1 (computes pc+4 into ALU out).
- WB_JAL: RegWrite=1, MtoR=0, AluSrcA=0, AluSrcB=2, PCWrite=1, PCSrc=1.
- WB_JALR: RegWrite=1, MtoR=0, AluSrcA=1, AluSrcB=2, PCWrite=1, PCSrc=2.
- Outputs not listed for a state are 0.
- RegWrite is asserted only in states 3, 6, 10, 12, 14, 16.

## Timing
- Reset: state=FETCH and taken=0. Outputs are current_stage=0, MemRead=1, AluSrcB=1, illegal_instr=0, and all other outputs 0. Reset mid-instruction abandons it with no writeback and no PC update.
- All outputs are Moore decodes of the registered state, except IRWrite (FETCH & mem_ready) and PCWrite in MEM_WR (MEM_WR & mem_ready).
- Cycle counts with mem_ready=1 always:
  - R/I-arith, LUI (3 cycles), AUIPC: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 4 cycles
  - JAL/JALR: 4 cycles
- Each wait cycle with mem_ready=0 adds one cycle. Outputs are held stable while waiting.
- Exactly one PCWrite pulse occurs per retired instruction.

## Configuration
- MULTICYCLE_ILLEGAL_TRAP_EN defined: an illegal opcode goes from DECODE to HALT. illegal_instr is set and held until reset. HALT drives all strobes to 0 and never leaves.
- MULTICYCLE_ILLEGAL_TRAP_EN undefined: an illegal opcode is treated as a NOP (PCWrite=1, PCSrc=0, go to FETCH). illegal_instr is tied to 0 and there is no HALT state.

## Test plan
- ADD x3,x1,x2 (0x002081B3), mem_ready=1: stages 0,1,2,3. In stage 3, RegWrite=1, MtoR=0, PCWrite=1, PCSrc=0.
- LW x5,8(x1), mem_ready=0 for 2 cycles in MEM_RD: stages 0,1,4,5,5,5,6. MemRead stays 1 during the waits. WB_LD has MtoR=1.
- BEQ: with alu_cond=1, BR_TGT gives PCSrc=1. With alu_cond=0, PCSrc=0. PCWrite=1 in both cases.
- JALR x1,0(x2): stages 0,1,15,16. In stage 16, RegWrite=1, AluSrcA=1, AluSrcB=2, PCSrc=2.
- Opcode 0x7F: with MULTICYCLE_ILLEGAL_TRAP_EN, current_stage=31 and illegal_instr=1 persist until reset. Without it, PCWrite pulses and the FSM returns to FETCH.
- Assert reset during MEM_WR: MemWrite drops immediately, current_stage=0 and MemRead=1, and no PCWrite pulse occurs.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM for the multicycle RV32I core
// Optional: `define MULTICYCLE_ILLEGAL_TRAP_EN traps illegal opcodes into a sticky HALT state.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_cond,
  output logic [4:0]  current_stage,
  output logic        RegWrite,
  output logic [1:0]  MtoR,
  output logic        AluSrcA,
  output logic [1:0]  AluSrcB,
  output logic [1:0]  alu_op,
  output logic        IRWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        illegal_instr
);

  typedef enum logic [4:0] {
    FETCH     = 5'd0,
    DECODE    = 5'd1,
    EXEC      = 5'd2,
    WB_ALU    = 5'd3,
    MEM_ADDR  = 5'd4,
    MEM_RD    = 5'd5,
    WB_LD     = 5'd6,
    MEM_WR    = 5'd7,
    BR_CMP    = 5'd8,
    BR_TGT    = 5'd9,
    WB_LUI    = 5'd10,
    AUIPC_EX  = 5'd11,
    WB_AUIPC  = 5'd12,
    JAL_LINK  = 5'd13,
    WB_JAL    = 5'd14,
    JALR_LINK = 5'd15,
    WB_JALR   = 5'd16
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , HALT    = 5'd31
`endif
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t     state;
  logic       taken;
  logic [6:0] opcode;
  logic       is_nop;
  logic       is_legal;
  logic       decode_retire;
  logic       unused_instr_bits;

  assign opcode            = instr[6:0];
  assign unused_instr_bits = ^instr[31:7];
  assign is_nop            = (opcode == OP_FENCE) || (opcode == OP_SYSTEM);

  always_comb begin
    is_legal = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI,
      OP_AUIPC, OP_JAL, OP_JALR, OP_FENCE, OP_SYSTEM: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  end

  // Instructions that retire straight out of DECODE bump the PC there.
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign decode_retire = is_nop;
`else
  assign decode_retire = is_nop || !is_legal;
`endif

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      taken <= 1'b0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH:     if (mem_ready) state <= DECODE;
        DECODE: begin
          case (opcode)
            OP_R, OP_I:          state <= EXEC;
            OP_LOAD, OP_STORE:   state <= MEM_ADDR;
            OP_BRANCH:           state <= BR_CMP;
            OP_LUI:              state <= WB_LUI;
            OP_AUIPC:            state <= AUIPC_EX;
            OP_JAL:              state <= JAL_LINK;
            OP_JALR:             state <= JALR_LINK;
            OP_FENCE, OP_SYSTEM: state <= FETCH;
            default: begin
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
              state     <= HALT;
              illegal_q <= 1'b1;
`else
              state     <= FETCH;
`endif
            end
          endcase
        end
        EXEC:      state <= WB_ALU;
        MEM_ADDR:  state <= (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
        MEM_RD:    if (mem_ready) state <= WB_LD;
        MEM_WR:    if (mem_ready) state <= FETCH;
        BR_CMP: begin
          taken <= alu_cond;
          state <= BR_TGT;
        end
        AUIPC_EX:  state <= WB_AUIPC;
        JAL_LINK:  state <= WB_JAL;
        JALR_LINK: state <= WB_JALR;
        WB_ALU, WB_LD, BR_TGT, WB_LUI, WB_AUIPC, WB_JAL, WB_JALR: state <= FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        HALT:      state <= HALT;
`endif
        default:   state <= FETCH;
      endcase
    end
  end

  always_comb begin
    current_stage = state;
    RegWrite      = 1'b0;
    MtoR          = 2'd0;
    AluSrcA       = 1'b0;
    AluSrcB       = 2'd0;
    alu_op        = 2'd0;
    IRWrite       = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    PCWrite       = 1'b0;
    PCSrc         = 2'd0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        AluSrcB = 2'd1;
        IRWrite = mem_ready;
      end
      DECODE:    PCWrite = decode_retire;
      EXEC: begin
        AluSrcA = 1'b1;
        if (opcode == OP_R) begin
          AluSrcB = 2'd0;
          alu_op  = 2'd1;
        end else begin
          AluSrcB = 2'd2;
          alu_op  = 2'd2;
        end
      end
      WB_ALU, WB_AUIPC: begin
        RegWrite = 1'b1;
        PCWrite  = 1'b1;
      end
      MEM_ADDR: begin
        AluSrcA = 1'b1;
        AluSrcB = 2'd2;
      end
      MEM_RD:    MemRead = 1'b1;
      WB_LD: begin
        RegWrite = 1'b1;
        MtoR     = 2'd1;
        PCWrite  = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        PCWrite  = mem_ready;
      end
      BR_CMP: begin
        AluSrcA = 1'b1;
        alu_op  = 2'd3;
      end
      BR_TGT: begin
        AluSrcB = 2'd2;
        PCWrite = 1'b1;
        PCSrc   = taken ? 2'd1 : 2'd0;
      end
      WB_LUI: begin
        RegWrite = 1'b1;
        MtoR     = 2'd2;
        PCWrite  = 1'b1;
      end
      AUIPC_EX:  AluSrcB = 2'd2;
      JAL_LINK, JALR_LINK: AluSrcB = 2'd1;
      WB_JAL: begin
        RegWrite = 1'b1;
        AluSrcB  = 2'd2;
        PCWrite  = 1'b1;
        PCSrc    = 2'd1;
      end
      WB_JALR: begin
        RegWrite = 1'b1;
        AluSrcA  = 1'b1;
        AluSrcB  = 2'd2;
        PCWrite  = 1'b1;
        PCSrc    = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
// Honours MULTICYCLE_ILLEGAL_TRAP_EN when deciding what an illegal opcode must do.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_cond;
  logic [4:0]  current_stage;
  logic        RegWrite;
  logic [1:0]  MtoR;
  logic        AluSrcA;
  logic [1:0]  AluSrcB;
  logic [1:0]  alu_op;
  logic        IRWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic        illegal_instr;

  multicycle_control dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .alu_cond(alu_cond),
    .current_stage(current_stage), .RegWrite(RegWrite), .MtoR(MtoR), .AluSrcA(AluSrcA),
    .AluSrcB(AluSrcB), .alu_op(alu_op), .IRWrite(IRWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] st;
    logic       rdy;
    logic       cond;
    logic       rw;
    logic [1:0] mtor;
    logic       a;
    logic [1:0] b;
    logic [1:0] op;
    logic       irw;
    logic       mr;
    logic       mw;
    logic       pcw;
    logic [1:0] pcs;
    logic       ill;
  } step_t;

  int    checks = 0;
  int    errors = 0;
  step_t plan_q[$];
  step_t cur;
  logic  chk_en = 1'b0;
  logic  plan_cond;
  logic  plan_ill;
  int    trace[$];
  int    exp_trace[$];
  int    pcw_count;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input int st, input int rdy, input int rw, input int mtor, input int a,
                     input int b, input int op, input int mr, input int mw, input int pcw,
                     input int pcs);
    step_t s;
    s.st   = st[4:0];
    s.rdy  = rdy[0];
    s.cond = plan_cond;
    s.rw   = rw[0];
    s.mtor = mtor[1:0];
    s.a    = a[0];
    s.b    = b[1:0];
    s.op   = op[1:0];
    s.irw  = (st == 0) && (rdy != 0);
    s.mr   = mr[0];
    s.mw   = mw[0];
    s.pcw  = pcw[0];
    s.pcs  = pcs[1:0];
    s.ill  = plan_ill;
    plan_q.push_back(s);
  endtask

  // Behavioural model: the per-instruction cycle plan written straight from the ISA class.
  task automatic build_plan(input logic [31:0] ins, input int fw, input int mw, input logic cond);
    logic [6:0] opc;
    bit         nop_like;
    bit         known;
    opc       = ins[6:0];
    plan_q.delete();
    plan_cond = 1'b0;
    plan_ill  = 1'b0;
    known     = opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0001111,
                            7'b1110011};
    nop_like  = (opc == 7'b0001111) || (opc == 7'b1110011) || (!known && !TRAP);
    for (int i = 0; i < fw; i++) add(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, nop_like ? 1 : 0, 0);
    case (opc)
      7'b0110011: begin add(2, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0); add(3, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0); end
      7'b0010011: begin add(2, 1, 0, 0, 1, 2, 2, 0, 0, 0, 0); add(3, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0); end
      7'b0000011: begin
        add(4, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0);
        for (int i = 0; i < mw; i++) add(5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        add(6, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
      end
      7'b0100011: begin
        add(4, 1, 0, 0, 1, 2, 0, 0, 0, 0, 0);
        for (int i = 0; i < mw; i++) add(7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(7, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      end
      7'b1100011: begin
        plan_cond = cond;
        add(8, 1, 0, 0, 1, 0, 3, 0, 0, 0, 0);
        plan_cond = ~cond;
        add(9, 1, 0, 0, 0, 2, 0, 0, 0, 1, cond ? 1 : 0);
      end
      7'b0110111: add(10, 1, 1, 2, 0, 0, 0, 0, 0, 1, 0);
      7'b0010111: begin add(11, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0); add(12, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0); end
      7'b1101111: begin add(13, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0); add(14, 1, 1, 0, 0, 2, 0, 0, 0, 1, 1); end
      7'b1100111: begin add(15, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0); add(16, 1, 1, 0, 1, 2, 0, 0, 0, 1, 2); end
      default: if (!known && TRAP) begin
        plan_ill = 1'b1;
        for (int i = 0; i < 3; i++) add(31, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      end
    endcase
  endtask

  task automatic drive_step(input step_t s);
    cur       = s;
    mem_ready = s.rdy;
    alu_cond  = s.cond;
    chk_en    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string name, input logic [31:0] ins, input int fw, input int mw,
                           input logic cond, input int len, input int pulses);
    build_plan(ins, fw, mw, cond);
    chk({name, "_plan_len"}, plan_q.size(), len);
    instr = ins;
    trace.delete();
    pcw_count = 0;
    foreach (plan_q[i]) drive_step(plan_q[i]);
    chk_en = 1'b0;
    chk({name, "_pcwrite_pulses"}, pcw_count, pulses);
  endtask

  task automatic check_trace(input string name);
    chk({name, "_trace_len"}, trace.size(), exp_trace.size());
    foreach (exp_trace[i])
      if (i < trace.size()) chk($sformatf("%s_stage%0d", name, i), trace[i], exp_trace[i]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      trace.push_back(int'(current_stage));
      if (PCWrite) pcw_count++;
      chk("current_stage", current_stage, cur.st);
      chk("RegWrite", RegWrite, cur.rw);
      chk("MtoR", MtoR, cur.mtor);
      chk("AluSrcA", AluSrcA, cur.a);
      chk("AluSrcB", AluSrcB, cur.b);
      chk("alu_op", alu_op, cur.op);
      chk("IRWrite", IRWrite, cur.irw);
      chk("MemRead", MemRead, cur.mr);
      chk("MemWrite", MemWrite, cur.mw);
      chk("PCWrite", PCWrite, cur.pcw);
      chk("PCSrc", PCSrc, cur.pcs);
      chk("illegal_instr", illegal_instr, cur.ill);
    end
  end

  initial begin
    reset     = 1'b1;
    instr     = 32'h0;
    mem_ready = 1'b0;
    alu_cond  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stage", current_stage, 0);
    chk("rst_MemRead", MemRead, 1);
    chk("rst_AluSrcB", AluSrcB, 1);
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_PCWrite", PCWrite, 0);
    chk("rst_MemWrite", MemWrite, 0);
    chk("rst_illegal", illegal_instr, 0);
    reset = 1'b0;

    run_instr("add", 32'h002081B3, 0, 0, 1'b0, 4, 1);
    exp_trace = '{0, 1, 2, 3};
    check_trace("add");
    run_instr("addi_fetchwait", 32'h00500093, 2, 0, 1'b0, 6, 1);
    run_instr("lw_wait2", 32'h0080A283, 0, 2, 1'b0, 7, 1);
    exp_trace = '{0, 1, 4, 5, 5, 5, 6};
    check_trace("lw");
    run_instr("sw_wait1", 32'h0020A223, 1, 1, 1'b0, 6, 1);
    run_instr("beq_taken", 32'h00208463, 0, 0, 1'b1, 4, 1);
    run_instr("beq_not", 32'h00208463, 0, 0, 1'b0, 4, 1);
    run_instr("lui", 32'h123453B7, 0, 0, 1'b0, 3, 1);
    run_instr("auipc", 32'h00001217, 0, 0, 1'b0, 4, 1);
    run_instr("jal", 32'h010000EF, 0, 0, 1'b0, 4, 1);
    run_instr("jalr", 32'h000100E7, 0, 0, 1'b0, 4, 1);
    exp_trace = '{0, 1, 15, 16};
    check_trace("jalr");
    run_instr("fence", 32'h0000000F, 0, 0, 1'b0, 2, 1);
    run_instr("ecall", 32'h00000073, 0, 0, 1'b0, 2, 1);

    // Reset lands while a store waits on memory.
    build_plan(32'h0020A223, 0, 3, 1'b0);
    instr = 32'h0020A223;
    for (int i = 0; i < plan_q.size() && plan_q[i].st != 5'd7; i++) drive_step(plan_q[i]);
    chk_en    = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("memwr_stage", current_stage, 7);
    chk("memwr_MemWrite", MemWrite, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("rstmid_MemWrite", MemWrite, 0);
    chk("rstmid_stage", current_stage, 0);
    chk("rstmid_MemRead", MemRead, 1);
    chk("rstmid_PCWrite", PCWrite, 0);
    mem_ready = 1'b1;
    #1;
    chk("rstmid_PCWrite_ready", PCWrite, 0);
    chk("rstmid_RegWrite", RegWrite, 0);
    @(posedge clk);
    #1;
    chk("rstheld_stage", current_stage, 0);
    chk("rstheld_PCWrite", PCWrite, 0);
    reset = 1'b0;

    run_instr("illegal", 32'h0000007F, 0, 0, 1'b0, TRAP ? 5 : 2, TRAP ? 0 : 1);
    if (TRAP) begin
      chk("halt_stage", current_stage, 31);
      chk("halt_illegal", illegal_instr, 1);
      reset = 1'b1;
      #1;
      chk("halt_rst_stage", current_stage, 0);
      chk("halt_rst_illegal", illegal_instr, 0);
      reset = 1'b0;
    end else begin
      chk("nop_illegal_stage", current_stage, 0);
      chk("nop_illegal_flag", illegal_instr, 0);
    end
    run_instr("add_after", 32'h002081B3, 0, 0, 1'b0, 4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
